ts_pcr_rx: RTL and testbench

- Receive-side TS packet parser on the byte stream (ts_sync/ts_valid/ts_data) that pcr_pro and ts_gen drive.
- Checks 188-byte packet framing and sync byte.
- Extracts PID and PCR (33-bit base + 9-bit extension) from the adaptation field and emits one pulse per PCR found.
- Used as the checking end of the PCR path: benches compare PCR before and after correction, and the block monitors the output TS in-system.

---
 rtl/ts_pkg.sv | 19 +
 rtl/sat_cnt.sv | 23 ++
 rtl/ts_pcr_rx.sv | 173 +++++++++++++++++
 tb/tb_ts_pcr_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared constants and FSM encoding for the TS packet receive path.
package ts_pkg;

   localparam int unsigned TS_PKT_LEN   = 188;
   localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
   localparam int unsigned PCR_BASE_W   = 33;
   localparam int unsigned PCR_EXT_W    = 9;
   localparam int unsigned PID_W        = 13;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_AF_LEN,
      ST_AF_FLAGS,
      ST_PCR,
      ST_SKIP
   } ts_state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ts_pcr_rx.sv
// TS packet receiver: checks 188-byte framing and sync byte, extracts PID and
// adaptation-field PCR, and counts good packets and framing errors.
module ts_pcr_rx
   import ts_pkg::*;
#(
   parameter bit              PID_FILTER_EN = 1'b0,
   parameter logic [PID_W-1:0] PCR_PID      = 13'h0100,
   parameter int unsigned     CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ts_sync,
   input  logic                  ts_valid,
   input  logic [7:0]            ts_data,
   output logic                  pcr_valid,
   output logic [PID_W-1:0]      pcr_pid,
   output logic [PCR_BASE_W-1:0] pcr_base,
   output logic [PCR_EXT_W-1:0]  pcr_ext,
   output logic [CNT_W-1:0]      pkt_cnt,
   output logic [CNT_W-1:0]      sync_err_cnt,
   output logic                  err_pulse
);

   localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);

   ts_state_e             state_q, state_d;
   logic [7:0]            idx_q, idx_d;
   logic [PID_W-1:0]      pid_q, pid_d;
   logic [PCR_BASE_W-1:0] base_sh_q, base_sh_d;
   logic                  ext_hi_q, ext_hi_d;
   logic                  pcr_valid_q, pcr_valid_d;
   logic [PID_W-1:0]      pcr_pid_q, pcr_pid_d;
   logic [PCR_BASE_W-1:0] pcr_base_q, pcr_base_d;
   logic [PCR_EXT_W-1:0]  pcr_ext_q, pcr_ext_d;
   logic                  err_q, err_d;
   logic                  pkt_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         pid_q       <= '0;
         base_sh_q   <= '0;
         ext_hi_q    <= 1'b0;
         pcr_valid_q <= 1'b0;
         pcr_pid_q   <= '0;
         pcr_base_q  <= '0;
         pcr_ext_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pid_q       <= pid_d;
         base_sh_q   <= base_sh_d;
         ext_hi_q    <= ext_hi_d;
         pcr_valid_q <= pcr_valid_d;
         pcr_pid_q   <= pcr_pid_d;
         pcr_base_q  <= pcr_base_d;
         pcr_ext_q   <= pcr_ext_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pid_d       = pid_q;
      base_sh_d   = base_sh_q;
      ext_hi_d    = ext_hi_q;
      pcr_valid_d = 1'b0;
      pcr_pid_d   = pcr_pid_q;
      pcr_base_d  = pcr_base_q;
      pcr_ext_d   = pcr_ext_q;
      err_d       = 1'b0;
      pkt_inc     = 1'b0;

      if (ts_valid) begin
         if (ts_sync && (state_q != ST_IDLE)) begin
            // Short packet: a new sync byte restarts framing in the same cycle
            err_d = 1'b1;
            if (ts_data == TS_SYNC_BYTE) begin
               state_d = ST_HDR;
               idx_d   = 8'd1;
            end else begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (ts_sync) begin
                     if (ts_data == TS_SYNC_BYTE) begin
                        state_d = ST_HDR;
                        idx_d   = 8'd1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end
               ST_HDR: begin
                  idx_d = idx_q + 8'd1;
                  case (idx_q)
                     8'd1:    pid_d[12:8] = ts_data[4:0];
                     8'd2:    pid_d[7:0]  = ts_data;
                     default: state_d = ts_data[5] ? ST_AF_LEN : ST_SKIP;
                  endcase
               end
               ST_AF_LEN: begin
                  idx_d   = idx_q + 8'd1;
                  state_d = (ts_data >= 8'd7) ? ST_AF_FLAGS : ST_SKIP;
               end
               ST_AF_FLAGS: begin
                  idx_d   = idx_q + 8'd1;
                  state_d = ts_data[4] ? ST_PCR : ST_SKIP;
               end
               ST_PCR: begin
                  idx_d = idx_q + 8'd1;
                  // Only the 42 meaningful PCR bits are kept: byte 10 contributes
                  // base[0] (bit 7) and ext[8] (bit 0); its reserved bits are dropped.
                  if (idx_q == 8'd10) begin
                     base_sh_d = {base_sh_q[31:0], ts_data[7]};
                     ext_hi_d  = ts_data[0];
                  end else if (idx_q == 8'd11) begin
                     state_d = ST_SKIP;
                     if (!PID_FILTER_EN || (pid_q == PCR_PID)) begin
                        pcr_valid_d = 1'b1;
                        pcr_pid_d   = pid_q;
                        pcr_base_d  = base_sh_q;
                        pcr_ext_d   = {ext_hi_q, ts_data};
                     end
                  end else begin
                     base_sh_d = {base_sh_q[24:0], ts_data};
                  end
               end
               ST_SKIP: begin
                  if (idx_q == LAST_IDX) begin
                     pkt_inc = 1'b1;
                     state_d = ST_IDLE;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 8'd1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end
            endcase
         end
      end
   end

   sat_cnt #(.W(CNT_W)) u_pkt_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (pkt_inc),
      .cnt_o (pkt_cnt)
   );

   sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (err_d),
      .cnt_o (sync_err_cnt)
   );

   assign pcr_valid = pcr_valid_q;
   assign pcr_pid   = pcr_pid_q;
   assign pcr_base  = pcr_base_q;
   assign pcr_ext   = pcr_ext_q;
   assign err_pulse = err_q;

endmodule

// File: tb/tb_ts_pcr_rx.sv
// Scoreboard bench: two receivers (unfiltered/16-bit, PID-filtered/4-bit) share one byte stream.
module tb_ts_pcr_rx;
   import ts_pkg::*;

   logic clk = 1'b0;
   logic rst, ts_sync, ts_valid;
   logic [7:0] ts_data;

   logic        a_pcr_valid, a_err_pulse, b_pcr_valid, b_err_pulse;
   logic [12:0] a_pcr_pid, b_pcr_pid;
   logic [32:0] a_pcr_base, b_pcr_base;
   logic [8:0]  a_pcr_ext, b_pcr_ext;
   logic [15:0] a_pkt_cnt, a_err_cnt;
   logic [3:0]  b_pkt_cnt, b_err_cnt;

   ts_pcr_rx #(.PID_FILTER_EN(1'b0), .PCR_PID(13'h0100), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_data(ts_data),
      .pcr_valid(a_pcr_valid), .pcr_pid(a_pcr_pid), .pcr_base(a_pcr_base), .pcr_ext(a_pcr_ext),
      .pkt_cnt(a_pkt_cnt), .sync_err_cnt(a_err_cnt), .err_pulse(a_err_pulse));

   ts_pcr_rx #(.PID_FILTER_EN(1'b1), .PCR_PID(13'h0100), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_data(ts_data),
      .pcr_valid(b_pcr_valid), .pcr_pid(b_pcr_pid), .pcr_base(b_pcr_base), .pcr_ext(b_pcr_ext),
      .pkt_cnt(b_pkt_cnt), .sync_err_cnt(b_err_cnt), .err_pulse(b_err_pulse));

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned due;
      logic [12:0] pid;
      logic [32:0] base;
      logic [8:0]  ext;
   } ev_t;

   typedef struct {
      logic [12:0] pid;
      logic [1:0]  afc;
      logic [7:0]  aflen;
      logic [7:0]  flags;
      logic [7:0]  first;
      logic [32:0] base;
      logic [8:0]  ext;
      logic [5:0]  rsv;
      int unsigned cut;
   } pkt_t;

   ev_t qa[$], qb[$];
   int unsigned total = 0, bad = 0;
   int unsigned m_pkt = 0, m_err = 0, a_errs_seen = 0, b_errs_seen = 0;
   bit in_pkt = 1'b0, gap3 = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sat(input int unsigned v, input int unsigned w);
      int unsigned mx;
      mx = (32'd1 << w) - 1;
      return (v > mx) ? 64'(mx) : 64'(v);
   endfunction

   always @(negedge clk) begin : mon
      ev_t e;
      if (a_err_pulse) a_errs_seen++;
      if (b_err_pulse) b_errs_seen++;
      if (a_pcr_valid) begin
         if (qa.size() == 0) chk("a_pcr_unexpected", 64'd1, 64'd0);
         else begin
            e = qa.pop_front();
            chk("a_pcr_cycle", 64'(cyc), 64'(e.due));
            chk("a_pcr_pid", 64'(a_pcr_pid), 64'(e.pid));
            chk("a_pcr_base", 64'(a_pcr_base), 64'(e.base));
            chk("a_pcr_ext", 64'(a_pcr_ext), 64'(e.ext));
         end
      end
      if (b_pcr_valid) begin
         if (qb.size() == 0) chk("b_pcr_unexpected", 64'd1, 64'd0);
         else begin
            e = qb.pop_front();
            chk("b_pcr_cycle", 64'(cyc), 64'(e.due));
            chk("b_pcr_pid", 64'(b_pcr_pid), 64'(e.pid));
            chk("b_pcr_base", 64'(b_pcr_base), 64'(e.base));
            chk("b_pcr_ext", 64'(b_pcr_ext), 64'(e.ext));
         end
      end
   end

   task automatic send_byte(input bit s, input logic [7:0] d);
      int unsigned g;
      g = gap3 ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      repeat (g) begin
         ts_valid = 1'b0; ts_sync = 1'($urandom); ts_data = 8'($urandom);
         @(posedge clk); #1;
      end
      ts_valid = 1'b1; ts_sync = s; ts_data = d;
      @(posedge clk); #1;
      ts_valid = 1'b0; ts_sync = 1'b0;
   endtask

   task automatic check_counts();
      @(negedge clk); #1;
      chk("a_pcr_missing", 64'(qa.size()), 64'd0);
      chk("b_pcr_missing", 64'(qb.size()), 64'd0);
      chk("a_pkt_cnt", 64'(a_pkt_cnt), sat(m_pkt, 16));
      chk("b_pkt_cnt", 64'(b_pkt_cnt), sat(m_pkt, 4));
      chk("a_sync_err_cnt", 64'(a_err_cnt), sat(m_err, 16));
      chk("b_sync_err_cnt", 64'(b_err_cnt), sat(m_err, 4));
      chk("a_err_pulses", 64'(a_errs_seen), 64'(m_err));
      chk("b_err_pulses", 64'(b_errs_seen), 64'(m_err));
   endtask

   task automatic send_pkt(input pkt_t p);
      logic [7:0] b [188];
      bit will_pcr;
      ev_t e;
      b[0]  = p.first;
      b[1]  = {3'($urandom), p.pid[12:8]};
      b[2]  = p.pid[7:0];
      b[3]  = {2'($urandom), p.afc, 4'($urandom)};
      b[4]  = p.aflen;
      b[5]  = p.flags;
      b[6]  = p.base[32:25];
      b[7]  = p.base[24:17];
      b[8]  = p.base[16:9];
      b[9]  = p.base[8:1];
      b[10] = {p.base[0], p.rsv, p.ext[8]};
      b[11] = p.ext[7:0];
      for (int i = 12; i < 188; i++) b[i] = 8'($urandom);
      // Packet-level model: any sync while framed or a bad sync byte is one error
      if (in_pkt || (p.first != TS_SYNC_BYTE)) m_err++;
      in_pkt = (p.first == TS_SYNC_BYTE);
      will_pcr = in_pkt && p.afc[1] && (p.aflen >= 8'd7) && p.flags[4] && (p.cut >= 12);
      for (int i = 0; i < int'(p.cut); i++) begin
         send_byte(i == 0, b[i]);
         if (i == 11 && will_pcr) begin
            e.due = cyc; e.pid = p.pid; e.base = p.base; e.ext = p.ext;
            qa.push_back(e);
            if (p.pid == 13'h0100) qb.push_back(e);
         end
      end
      if (in_pkt && p.cut == 188) begin
         m_pkt++;
         in_pkt = 1'b0;
      end
      check_counts();
   endtask

   task automatic do_reset();
      rst = 1'b1; ts_valid = 1'b0; ts_sync = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_pkt = 0; m_err = 0; in_pkt = 1'b0;
      a_errs_seen = 0; b_errs_seen = 0;
      qa.delete(); qb.delete();
      chk("rst_a_pcr_valid", 64'(a_pcr_valid), 64'd0);
      chk("rst_a_pcr_pid", 64'(a_pcr_pid), 64'd0);
      chk("rst_a_pcr_base", 64'(a_pcr_base), 64'd0);
      chk("rst_a_pcr_ext", 64'(a_pcr_ext), 64'd0);
      chk("rst_a_pkt_cnt", 64'(a_pkt_cnt), 64'd0);
      chk("rst_a_err_cnt", 64'(a_err_cnt), 64'd0);
      chk("rst_a_err_pulse", 64'(a_err_pulse), 64'd0);
      chk("rst_b_outputs", 64'({b_pcr_valid, b_pcr_pid, b_pcr_base, b_pcr_ext, b_pkt_cnt, b_err_cnt, b_err_pulse}), 64'd0);
   endtask

   function automatic pkt_t mk(input logic [12:0] pid, input logic [1:0] afc, input logic [7:0] aflen,
                               input logic [7:0] flags, input logic [7:0] first, input int unsigned cut);
      pkt_t p;
      p.pid = pid; p.afc = afc; p.aflen = aflen; p.flags = flags; p.first = first; p.cut = cut;
      p.base = 33'h02468ACF1; p.ext = 9'h02B; p.rsv = 6'h00;
      return p;
   endfunction

   initial begin
      pkt_t p;
      rst = 1'b1; ts_valid = 1'b0; ts_sync = 1'b0; ts_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 188));
      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h00, 8'h47, 188));
      send_pkt(mk(13'h0100, 2'd1, 8'd7, 8'h10, 8'h47, 188));
      send_pkt(mk(13'h0200, 2'd3, 8'd7, 8'h10, 8'h47, 188));
      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 188));
      send_pkt(mk(13'h0100, 2'd2, 8'd6, 8'h10, 8'h47, 188));
      send_pkt(mk(13'h0100, 2'd2, 8'd183, 8'hFF, 8'h47, 188));

      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h48, 188));
      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 188));

      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 100));
      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 188));

      gap3 = 1'b1;
      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 50));
      do_reset();
      send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h47, 188));
      gap3 = 1'b0;

      repeat (20) send_pkt(mk(13'h0100, 2'd3, 8'd7, 8'h10, 8'h48, 1));

      repeat (40) begin
         p.pid   = ($urandom_range(0, 1) == 0) ? 13'h0100 : 13'($urandom);
         p.afc   = 2'($urandom);
         p.aflen = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(7, 183)) : 8'($urandom_range(0, 8));
         p.flags = 8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h10 : 8'h00);
         p.first = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h47;
         p.base  = {1'($urandom), 32'($urandom)};
         p.ext   = 9'($urandom_range(0, 299));
         p.rsv   = 6'($urandom);
         p.cut   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 187) : 188;
         send_pkt(p);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
